// File: rtl/accl_pkg.sv
// Shared constants, scheduler state encoding and the in-flight pair tag for the getAccl pair scheduler.
package accl_pkg;

   localparam int unsigned ACCL_IDX_W   = 8;
   localparam int unsigned ACCL_LATENCY = 122;
   localparam int unsigned ACCL_RD_LAT  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic                  vld;
      logic                  last;
      logic [ACCL_IDX_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/accl_tag_delay.sv
// Tag delay line that shadows the body-memory read and the getAccl pipeline.
// Taps: RD_LAT (pipeline input valid) and RD_LAT+LATENCY (result tag).
module accl_tag_delay
   import accl_pkg::*;
#(
   parameter int unsigned RD_LAT  = ACCL_RD_LAT,
   parameter int unsigned LATENCY = ACCL_LATENCY
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output logic pipe_vld,
   output tag_t tag_res
);

   localparam int unsigned DEPTH = RD_LAT + LATENCY;

   tag_t sr [DEPTH];

   // Whole tags are cleared so result fields read 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < DEPTH; k++) sr[k] <= '0;
      end else begin
         sr[0] <= tag_in;
         for (int unsigned k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
      end
   end

   assign pipe_vld = sr[RD_LAT-1].vld;
   assign tag_res  = sr[DEPTH-1];

endmodule

// File: rtl/accl_pair_scheduler.sv
// Issues every ordered body pair (i,j), i!=j, into the getAccl pipeline and tags its results.
// Optional feature macro ACCL_SCHED_PERF_EN adds pair_cnt / cycle_cnt outputs.
module accl_pair_scheduler
   import accl_pkg::*;
#(
   parameter  int unsigned LATENCY = ACCL_LATENCY,
   parameter  int unsigned RD_LAT  = ACCL_RD_LAT,
   localparam int unsigned IDX_W   = ACCL_IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W:0]   n_bodies,
   input  logic             issue_hold,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [IDX_W-1:0] rd_addr_i,
   output logic [IDX_W-1:0] rd_addr_j,
   output logic             pipe_vld,
   output logic             res_vld,
   output logic [IDX_W-1:0] res_idx,
`ifdef ACCL_SCHED_PERF_EN
   output logic [2*IDX_W-1:0] pair_cnt,
   output logic [31:0]        cycle_cnt,
`endif
   output logic             res_last
);

   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned INF_W = 2 * IDX_W + 1;
   localparam logic [CNT_W-1:0] N_MAX = CNT_W'(1) << IDX_W;

   sched_state_t     state_q, state_d;
   logic [CNT_W-1:0] n_q, n_d, i_q, i_d, j_q, j_d;
   logic [CNT_W-1:0] n_clamp, cur_n, cur_i, cur_j, j_inc, j_nx;
   logic             cur_go, last_j, last_pair;
   logic [INF_W-1:0] infl_q, infl_d;
   logic             rd_en_d, rd_last_q, rd_last_d, busy_d, done_d;
   logic [IDX_W-1:0] rd_i_d, rd_j_d;
   tag_t             tag_in, tag_res;

   assign n_clamp = (n_bodies > N_MAX) ? N_MAX : n_bodies;

   // Pair walker: the first pair is issued straight from IDLE so a pass has no start bubble.
   always_comb begin
      cur_go = 1'b0;
      cur_n  = n_q;
      cur_i  = i_q;
      cur_j  = j_q;
      if (state_q == IDLE) begin
         cur_n  = n_clamp;
         cur_i  = '0;
         cur_j  = CNT_W'(1);
         cur_go = start && (n_clamp >= CNT_W'(2));
      end else if (state_q == ISSUE) begin
         cur_go = 1'b1;
      end
      j_inc     = cur_j + CNT_W'(1);
      j_nx      = (j_inc == cur_i) ? cur_j + CNT_W'(2) : j_inc;
      last_j    = (j_nx >= cur_n);
      last_pair = last_j && (cur_i == cur_n - CNT_W'(1));
   end

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      i_d       = i_q;
      j_d       = j_q;
      rd_en_d   = 1'b0;
      rd_i_d    = '0;
      rd_j_d    = '0;
      rd_last_d = 1'b0;
      done_d    = 1'b0;
      infl_d    = infl_q + INF_W'(rd_en) - INF_W'(res_vld);
      case (state_q)
         IDLE: begin
            if (start) begin
               n_d     = n_clamp;
               i_d     = '0;
               j_d     = CNT_W'(1);
               state_d = (n_clamp < CNT_W'(2)) ? DRAIN : ISSUE;
            end
         end
         ISSUE: ;
         DRAIN: begin
            // A pair issued this cycle is not yet counted in infl_q.
            if ((infl_q == '0) && !rd_en) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (cur_go && !issue_hold) begin
         rd_en_d   = 1'b1;
         rd_i_d    = cur_i[IDX_W-1:0];
         rd_j_d    = cur_j[IDX_W-1:0];
         rd_last_d = last_j;
         if (last_pair) begin
            state_d = DRAIN;
         end else if (last_j) begin
            i_d = cur_i + CNT_W'(1);
            j_d = '0;
         end else begin
            j_d = j_nx;
         end
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         n_q       <= '0;
         i_q       <= '0;
         j_q       <= '0;
         infl_q    <= '0;
         rd_en     <= 1'b0;
         rd_addr_i <= '0;
         rd_addr_j <= '0;
         rd_last_q <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         i_q       <= i_d;
         j_q       <= j_d;
         infl_q    <= infl_d;
         rd_en     <= rd_en_d;
         rd_addr_i <= rd_i_d;
         rd_addr_j <= rd_j_d;
         rd_last_q <= rd_last_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   assign tag_in = '{vld: rd_en, last: rd_last_q, idx: rd_addr_i};

   accl_tag_delay #(
      .RD_LAT  (RD_LAT),
      .LATENCY (LATENCY)
   ) u_tag_delay (
      .clk      (clk),
      .rst      (rst),
      .tag_in   (tag_in),
      .pipe_vld (pipe_vld),
      .tag_res  (tag_res)
   );

   assign res_vld  = tag_res.vld;
   assign res_last = tag_res.last;
   assign res_idx  = tag_res.idx;

`ifdef ACCL_SCHED_PERF_EN
   // cycle_cnt reads k in the k-th cycle after the accepted start, so done sees start-to-done distance.
   always_ff @(posedge clk) begin
      if (rst) begin
         pair_cnt  <= '0;
         cycle_cnt <= '0;
      end else if ((state_q == IDLE) && start) begin
         pair_cnt  <= (2*IDX_W)'(rd_en_d);
         cycle_cnt <= 32'd1;
      end else if (state_q != IDLE) begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (rd_en_d) pair_cnt <= pair_cnt + (2*IDX_W)'(1);
      end
   end
`endif

endmodule

// File: tb/tb_accl_pair_scheduler.sv
// Directed and randomized bench for accl_pair_scheduler against a pair-list/timing reference model.
module tb_accl_pair_scheduler;
   import accl_pkg::*;

   localparam int IW   = ACCL_IDX_W;
   localparam int NW   = IW + 1;
   localparam int RDL  = ACCL_RD_LAT;
   localparam int PL   = ACCL_RD_LAT + ACCL_LATENCY;
   localparam int LOGN = 16384;

   logic          clk = 1'b0;
   logic          rst, start, issue_hold;
   logic [IW:0]   n_bodies;
   logic          busy, done, rd_en, pipe_vld, res_vld, res_last;
   logic [IW-1:0] rd_addr_i, rd_addr_j, res_idx;
`ifdef ACCL_SCHED_PERF_EN
   logic [2*IW-1:0] pair_cnt;
   logic [31:0]     cycle_cnt;
`endif

   accl_pair_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .n_bodies   (n_bodies),
      .issue_hold (issue_hold),
      .busy       (busy),
      .done       (done),
      .rd_en      (rd_en),
      .rd_addr_i  (rd_addr_i),
      .rd_addr_j  (rd_addr_j),
      .pipe_vld   (pipe_vld),
      .res_vld    (res_vld),
      .res_idx    (res_idx),
`ifdef ACCL_SCHED_PERF_EN
      .pair_cnt   (pair_cnt),
      .cycle_cnt  (cycle_cnt),
`endif
      .res_last   (res_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int cyc;
      int a;
      int b;
      bit l;
   } ev_t;

   ev_t q_rd[$], q_pv[$], q_res[$], q_done[$];
   ev_t e_rd[$];
   int  e_done;
   int  s;
   bit  hold_plan [0:1023];
   bit  busy_log  [0:LOGN-1];
   bit  any_log   [0:LOGN-1];
   int  n_cmp = 0;
   int  n_bad = 0;

   // Observe DUT outputs mid-cycle.
   always @(negedge clk) begin
      int pc, cc;
      pc = 0;
      cc = 0;
`ifdef ACCL_SCHED_PERF_EN
      pc = int'(pair_cnt);
      cc = int'(cycle_cnt);
`endif
      if (rd_en === 1'b1)    q_rd.push_back('{cyc, int'(rd_addr_i), int'(rd_addr_j), 1'b0});
      if (pipe_vld === 1'b1) q_pv.push_back('{cyc, 0, 0, 1'b0});
      if (res_vld === 1'b1)  q_res.push_back('{cyc, int'(res_idx), 0, res_last});
      if (done === 1'b1)     q_done.push_back('{cyc, pc, cc, 1'b0});
      if (cyc < LOGN) begin
         busy_log[cyc] = (busy === 1'b1);
         any_log[cyc]  = (|{busy, done, rd_en, pipe_vld, res_vld, res_last,
                            rd_addr_i, rd_addr_j, res_idx}) !== 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: ordered pair list, issue cycles from the hold trace, fixed result latency.
   task automatic build_model(input int n_req);
      int n, c, last_off;
      n = (n_req > (1 << IW)) ? (1 << IW) : n_req;
      e_rd.delete();
      c = 0;
      last_off = 0;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n; j++) begin
            if (i != j) begin
               while (hold_plan[c] && c < 1023) c++;
               e_rd.push_back('{c + 1, i, j, (j == ((i == n - 1) ? n - 2 : n - 1))});
               last_off = c + 1;
               c++;
            end
         end
      end
      e_done = (e_rd.size() == 0) ? 2 : last_off + PL + 2;
   endtask

   task automatic clear_hold();
      for (int k = 0; k < 1024; k++) hold_plan[k] = 1'b0;
   endtask

   task automatic run_pass(input int n_in, input int n_mid, input int restart_off,
                           input int rst_off, input int run_len);
      q_rd.delete();
      q_pv.delete();
      q_res.delete();
      q_done.delete();
      @(posedge clk);
      #1;
      n_bodies   = NW'(n_in);
      start      = 1'b1;
      issue_hold = hold_plan[0];
      s          = cyc;
      for (int k = 1; k < run_len; k++) begin
         @(posedge clk);
         #1;
         start = (k == restart_off);
         if (k == 1) n_bodies = NW'(n_mid);
         issue_hold = (k < 1024) ? hold_plan[k] : 1'b0;
         rst = (k == rst_off);
         if (rst_off == 0 && q_done.size() > 0) break;
      end
      start      = 1'b0;
      issue_hold = 1'b0;
      rst        = 1'b0;
   endtask

   task automatic compare_pass(input string tag);
      int nr;
      chk({tag, ".rd_count"}, 64'(q_rd.size()), 64'(e_rd.size()));
      nr = (q_rd.size() < e_rd.size()) ? q_rd.size() : e_rd.size();
      for (int k = 0; k < nr; k++) begin
         chk($sformatf("%s.rd%0d.cyc", tag, k), 64'(q_rd[k].cyc - s), 64'(e_rd[k].cyc));
         chk($sformatf("%s.rd%0d.i", tag, k), 64'(q_rd[k].a), 64'(e_rd[k].a));
         chk($sformatf("%s.rd%0d.j", tag, k), 64'(q_rd[k].b), 64'(e_rd[k].b));
      end
      chk({tag, ".pv_count"}, 64'(q_pv.size()), 64'(e_rd.size()));
      nr = (q_pv.size() < e_rd.size()) ? q_pv.size() : e_rd.size();
      for (int k = 0; k < nr; k++)
         chk($sformatf("%s.pv%0d.cyc", tag, k), 64'(q_pv[k].cyc - s), 64'(e_rd[k].cyc + RDL));
      chk({tag, ".res_count"}, 64'(q_res.size()), 64'(e_rd.size()));
      nr = (q_res.size() < e_rd.size()) ? q_res.size() : e_rd.size();
      for (int k = 0; k < nr; k++) begin
         chk($sformatf("%s.res%0d.cyc", tag, k), 64'(q_res[k].cyc - s), 64'(e_rd[k].cyc + PL));
         chk($sformatf("%s.res%0d.idx", tag, k), 64'(q_res[k].a), 64'(e_rd[k].a));
         chk($sformatf("%s.res%0d.last", tag, k), 64'(q_res[k].l), 64'(e_rd[k].l));
      end
      chk({tag, ".busy_after_start"}, 64'(busy_log[s + 1]), 64'd1);
      chk({tag, ".done_count"}, 64'(q_done.size()), 64'd1);
      if (q_done.size() > 0) begin
         chk({tag, ".done_cyc"}, 64'(q_done[0].cyc - s), 64'(e_done));
         chk({tag, ".busy_at_done"}, 64'(busy_log[q_done[0].cyc]), 64'd0);
`ifdef ACCL_SCHED_PERF_EN
         chk({tag, ".pair_cnt"}, 64'(q_done[0].a), 64'(e_rd.size()));
         chk({tag, ".cycle_cnt"}, 64'(q_done[0].b), 64'(e_done));
`endif
      end
   endtask

   initial begin
      int n;
      rst        = 1'b1;
      start      = 1'b0;
      issue_hold = 1'b0;
      n_bodies   = '0;
      clear_hold();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      chk("reset.rd_en", rd_en, 0);
      chk("reset.addr", {rd_addr_i, rd_addr_j}, 0);
      chk("reset.res", {pipe_vld, res_vld, res_last, res_idx}, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // n=3 back-to-back
      build_model(3);
      run_pass(3, 3, 0, 0, e_done + 20);
      compare_pass("n3");

      // degenerate sizes
      build_model(1);
      run_pass(1, 1, 0, 0, e_done + 20);
      compare_pass("n1");
      build_model(0);
      run_pass(0, 0, 0, 0, e_done + 20);
      compare_pass("n0");

      // n=4, hold for 5 cycles after the 3rd issue
      for (int k = 3; k < 8; k++) hold_plan[k] = 1'b1;
      build_model(4);
      run_pass(4, 4, 0, 0, e_done + 20);
      compare_pass("n4_hold");
      clear_hold();

      // restart and n_bodies change mid-pass are ignored
      build_model(3);
      run_pass(3, 8, 3, 0, e_done + 20);
      compare_pass("n3_restart");

      // reset at cycle 50 of an n=16 pass
      run_pass(16, 16, 0, 50, 251);
      chk("rst.rd_count", 64'(q_rd.size()), 64'd50);
      chk("rst.pv_count", 64'(q_pv.size()), 64'd49);
      chk("rst.res_count", 64'(q_res.size()), 64'd0);
      chk("rst.done_count", 64'(q_done.size()), 64'd0);
      chk("rst.outputs_after", 64'(any_log[s + 51]), 64'd0);
      build_model(2);
      run_pass(2, 2, 0, 0, e_done + 20);
      compare_pass("n2_after_rst");

      // randomized sizes and hold traces
      for (int r = 0; r < 6; r++) begin
         n = int'($urandom_range(2, 7));
         for (int k = 0; k < 1024; k++) hold_plan[k] = ($urandom_range(0, 3) == 0);
         build_model(n);
         run_pass(n, int'($urandom_range(0, 300)), int'($urandom_range(2, 20)), 0, e_done + 20);
         compare_pass($sformatf("rand%0d_n%0d", r, n));
      end
      clear_hold();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
